// File: rtl/security_alarm_controller.sv
// Four-zone intruder alarm: exit delay, debounced zone qualification, entry delay,
// timed siren with automatic re-arm, and a sticky record of the triggering zones.
module security_alarm_controller #(
    parameter int EXIT_DELAY  = 8,
    parameter int ENTRY_DELAY = 6,
    parameter int ALARM_TIME  = 20,
    parameter int DEBOUNCE    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       arm,
    input  logic       disarm,
    input  logic [3:0] zone_motion,
    input  logic [3:0] zone_mask,
    output logic       alarm,
    output logic       armed,
    output logic       pending,
    output logic [3:0] zone_latched,
    output logic [2:0] state
);

    localparam int MAX_A = (EXIT_DELAY > ENTRY_DELAY) ? EXIT_DELAY : ENTRY_DELAY;
    localparam int MAX_D = (MAX_A > ALARM_TIME) ? MAX_A : ALARM_TIME;
    localparam int CW    = $clog2(MAX_D) + 1;

    // Counter is loaded with delay-1 so a state lasts exactly "delay" cycles.
    localparam logic [CW-1:0] EXIT_LD  = CW'(EXIT_DELAY - 1);
    localparam logic [CW-1:0] ENTRY_LD = CW'(ENTRY_DELAY - 1);
    localparam logic [CW-1:0] ALARM_LD = CW'(ALARM_TIME - 1);
    localparam logic [3:0]    DEB      = 4'(DEBOUNCE);
    localparam logic [3:0]    DEB_M1   = 4'(DEBOUNCE - 1);

    typedef enum logic [2:0] {
        S_DISARMED   = 3'd0,
        S_EXIT_WAIT  = 3'd1,
        S_ARMED      = 3'd2,
        S_ENTRY_WAIT = 3'd3,
        S_ALARM      = 3'd4
    } state_t;

    state_t        cur;
    state_t        nxt;
    logic [CW-1:0] cnt;
    logic [3:0]    deb [4];
    logic [3:0]    hit;
    logic [3:0]    qual;

    assign state = cur;

    always_comb begin
        hit = zone_motion & ~zone_mask;
        for (int i = 0; i < 4; i++) begin
            qual[i] = hit[i] && (deb[i] >= DEB_M1);
        end
        nxt = cur;
        if (cur != S_DISARMED && disarm) begin
            nxt = S_DISARMED;
        end else begin
            case (cur)
                S_DISARMED:   if (arm) nxt = S_EXIT_WAIT;
                S_EXIT_WAIT:  if (cnt == '0) nxt = S_ARMED;
                S_ARMED:      if (|qual) nxt = S_ENTRY_WAIT;
                S_ENTRY_WAIT: if (cnt == '0) nxt = S_ALARM;
                S_ALARM:      if (cnt == '0) nxt = S_ARMED;
                default:      nxt = S_DISARMED;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur          <= S_DISARMED;
            cnt          <= '0;
            alarm        <= 1'b0;
            armed        <= 1'b0;
            pending      <= 1'b0;
            zone_latched <= 4'b0000;
            for (int i = 0; i < 4; i++) deb[i] <= 4'd0;
        end else begin
            cur     <= nxt;
            alarm   <= (nxt == S_ALARM);
            armed   <= (nxt == S_ARMED) || (nxt == S_ENTRY_WAIT) || (nxt == S_ALARM);
            pending <= (nxt == S_EXIT_WAIT) || (nxt == S_ENTRY_WAIT);

            if (nxt != cur) begin
                case (nxt)
                    S_EXIT_WAIT:  cnt <= EXIT_LD;
                    S_ENTRY_WAIT: cnt <= ENTRY_LD;
                    S_ALARM:      cnt <= ALARM_LD;
                    default:      cnt <= '0;
                endcase
            end else if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end

            if (nxt == S_DISARMED && cur != S_DISARMED) begin
                zone_latched <= 4'b0000;
            end else if (cur == S_ARMED && nxt == S_ENTRY_WAIT) begin
                zone_latched <= zone_latched | qual;
            end

            for (int i = 0; i < 4; i++) begin
                if (cur != S_ARMED || !hit[i]) deb[i] <= 4'd0;
                else if (deb[i] != DEB)        deb[i] <= deb[i] + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_security_alarm_controller.sv
// Directed scenarios plus a randomized run checked against a cycle-level behavioural model.
module tb_security_alarm_controller;

    localparam int EXIT_D  = 8;
    localparam int ENTRY_D = 6;
    localparam int ALARM_T = 20;
    localparam int DEB_N   = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       arm = 1'b0;
    logic       disarm = 1'b0;
    logic [3:0] zone_motion = 4'b0000;
    logic [3:0] zone_mask = 4'b0000;
    logic       alarm;
    logic       armed;
    logic       pending;
    logic [3:0] zone_latched;
    logic [2:0] state;

    int tests = 0;
    int fails = 0;

    // Behavioural model: state number, cycles remaining in a timed state,
    // consecutive qualifying samples per zone, sticky trigger record.
    int         m_state;
    int         m_rem;
    int         m_deb [4];
    logic [3:0] m_latch;

    security_alarm_controller #(
        .EXIT_DELAY(EXIT_D), .ENTRY_DELAY(ENTRY_D), .ALARM_TIME(ALARM_T), .DEBOUNCE(DEB_N)
    ) dut (
        .clk(clk), .reset(reset), .arm(arm), .disarm(disarm),
        .zone_motion(zone_motion), .zone_mask(zone_mask),
        .alarm(alarm), .armed(armed), .pending(pending),
        .zone_latched(zone_latched), .state(state)
    );

    always #5 clk = ~clk;

    wire [9:0] outs = {state, alarm, armed, pending, zone_latched};

    function automatic logic [9:0] exp_outs(input int st, input logic [3:0] lat);
        exp_outs = {3'(st), st == 4, st == 2 || st == 3 || st == 4, st == 1 || st == 3, lat};
    endfunction

    task automatic tick(input logic a, input logic d, input logic [3:0] m, input logic [3:0] k);
        arm = a; disarm = d; zone_motion = m; zone_mask = k;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(1'b0, 1'b0, 4'b0000, 4'b0000);
        reset = 1'b0;
    endtask

    task automatic arm_fully();
        do_reset();
        tick(1'b1, 1'b0, 4'b0000, 4'b0000);
        repeat (EXIT_D) tick(1'b0, 1'b0, 4'b0000, 4'b0000);
    endtask

    task automatic model_step(input logic r, input logic a, input logic d,
                              input logic [3:0] m, input logic [3:0] k);
        logic [3:0] q;
        if (r) begin
            m_state = 0; m_rem = 0; m_latch = 4'b0000;
            for (int i = 0; i < 4; i++) m_deb[i] = 0;
            return;
        end
        q = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            if (m_state == 2 && m[i] && !k[i]) m_deb[i] = (m_deb[i] + 1 > DEB_N) ? DEB_N : m_deb[i] + 1;
            else m_deb[i] = 0;
            if (m_deb[i] >= DEB_N) q[i] = 1'b1;
        end
        if (m_state != 0 && d) begin
            m_state = 0; m_latch = 4'b0000;
        end else begin
            case (m_state)
                0: if (a) begin m_state = 1; m_rem = EXIT_D; end
                1: begin m_rem--; if (m_rem == 0) m_state = 2; end
                2: if (q != 4'b0000) begin m_state = 3; m_rem = ENTRY_D; m_latch |= q; end
                3: begin m_rem--; if (m_rem == 0) begin m_state = 4; m_rem = ALARM_T; end end
                default: begin m_rem--; if (m_rem == 0) m_state = 2; end
            endcase
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(1'b1, 1'b0, 4'b1111, 4'b0000);
        tests++;
        if (outs !== exp_outs(0, 4'b0000)) begin
            fails++; $display("FAIL reset_state: got %b want %b", outs, exp_outs(0, 4'b0000));
        end
        reset = 1'b0;
    endtask

    task automatic test_arm_exit();
        do_reset();
        tick(1'b1, 1'b0, 4'b0000, 4'b0000);
        for (int k = 1; k <= EXIT_D; k++) begin
            tests++;
            if (outs !== exp_outs(1, 4'b0000)) begin
                fails++; $display("FAIL exit_wait k=%0d: got %b want %b", k, outs, exp_outs(1, 4'b0000));
            end
            tick(k == 3, 1'b0, 4'b0000, 4'b0000);
        end
        tests++;
        if (outs !== exp_outs(2, 4'b0000)) begin
            fails++; $display("FAIL exit_to_armed: got %b want %b", outs, exp_outs(2, 4'b0000));
        end
    endtask

    task automatic test_trigger_alarm();
        arm_fully();
        tick(1'b0, 1'b0, 4'b0010, 4'b0000);
        tests++;
        if (outs !== exp_outs(2, 4'b0000)) begin
            fails++; $display("FAIL debounce_first: got %b want %b", outs, exp_outs(2, 4'b0000));
        end
        tick(1'b0, 1'b0, 4'b0010, 4'b0000);
        for (int k = 0; k < ENTRY_D; k++) begin
            tests++;
            if (outs !== exp_outs(3, 4'b0010)) begin
                fails++; $display("FAIL entry_wait k=%0d: got %b want %b", k, outs, exp_outs(3, 4'b0010));
            end
            tick(1'b0, 1'b0, 4'b1111, 4'b0000);
        end
        for (int k = 0; k < ALARM_T; k++) begin
            tests++;
            if (outs !== exp_outs(4, 4'b0010)) begin
                fails++; $display("FAIL alarm_on k=%0d: got %b want %b", k, outs, exp_outs(4, 4'b0010));
            end
            tick(1'b0, 1'b0, 4'b0000, 4'b0000);
        end
        tests++;
        if (outs !== exp_outs(2, 4'b0010)) begin
            fails++; $display("FAIL auto_rearm: got %b want %b", outs, exp_outs(2, 4'b0010));
        end
        tick(1'b0, 1'b0, 4'b1000, 4'b0000);
        tick(1'b0, 1'b0, 4'b1000, 4'b0000);
        tests++;
        if (outs !== exp_outs(3, 4'b1010)) begin
            fails++; $display("FAIL latch_accumulate: got %b want %b", outs, exp_outs(3, 4'b1010));
        end
    endtask

    task automatic test_mask_glitch();
        arm_fully();
        tick(1'b0, 1'b0, 4'b0101, 4'b0100);
        for (int k = 0; k < 12; k++) begin
            tests++;
            if (outs !== exp_outs(2, 4'b0000)) begin
                fails++; $display("FAIL mask_glitch k=%0d: got %b want %b", k, outs, exp_outs(2, 4'b0000));
            end
            tick(1'b0, 1'b0, 4'b0100, 4'b0100);
        end
    endtask

    task automatic test_disarm_priority();
        arm_fully();
        tick(1'b0, 1'b0, 4'b0001, 4'b0000);
        tick(1'b0, 1'b0, 4'b0001, 4'b0000);
        tick(1'b1, 1'b1, 4'b1111, 4'b0000);
        tests++;
        if (outs !== exp_outs(0, 4'b0000)) begin
            fails++; $display("FAIL disarm_priority: got %b want %b", outs, exp_outs(0, 4'b0000));
        end
        for (int k = 0; k < ENTRY_D + ALARM_T; k++) begin
            tick(1'b0, 1'b0, 4'b1111, 4'b0000);
            tests++;
            if (outs !== exp_outs(0, 4'b0000)) begin
                fails++; $display("FAIL disarm_hold k=%0d: got %b want %b", k, outs, exp_outs(0, 4'b0000));
            end
        end
    endtask

    task automatic test_reset_mid_alarm();
        arm_fully();
        tick(1'b0, 1'b0, 4'b0100, 4'b0000);
        tick(1'b0, 1'b0, 4'b0100, 4'b0000);
        repeat (ENTRY_D + 4) tick(1'b0, 1'b0, 4'b0000, 4'b0000);
        tests++;
        if (outs !== exp_outs(4, 4'b0100)) begin
            fails++; $display("FAIL alarm_before_reset: got %b want %b", outs, exp_outs(4, 4'b0100));
        end
        reset = 1'b1;
        tick(1'b1, 1'b0, 4'b1111, 4'b0000);
        reset = 1'b0;
        tests++;
        if (outs !== exp_outs(0, 4'b0000)) begin
            fails++; $display("FAIL reset_mid_alarm: got %b want %b", outs, exp_outs(0, 4'b0000));
        end
        for (int k = 0; k < 10; k++) begin
            tick(1'b0, 1'b0, 4'b1111, 4'b0000);
            tests++;
            if (outs !== exp_outs(0, 4'b0000)) begin
                fails++; $display("FAIL post_reset k=%0d: got %b want %b", k, outs, exp_outs(0, 4'b0000));
            end
        end
    endtask

    task automatic test_exit_motion();
        do_reset();
        tick(1'b1, 1'b0, 4'b1111, 4'b0000);
        repeat (EXIT_D - 2) tick(1'b0, 1'b0, 4'b1111, 4'b0000);
        tick(1'b0, 1'b0, 4'b0000, 4'b0000);
        tests++;
        if (outs !== exp_outs(1, 4'b0000)) begin
            fails++; $display("FAIL exit_motion_wait: got %b want %b", outs, exp_outs(1, 4'b0000));
        end
        for (int k = 0; k < 6; k++) begin
            tick(1'b0, 1'b0, 4'b0000, 4'b0000);
            tests++;
            if (outs !== exp_outs(2, 4'b0000)) begin
                fails++; $display("FAIL exit_motion_armed k=%0d: got %b want %b", k, outs, exp_outs(2, 4'b0000));
            end
        end
    endtask

    task automatic test_random();
        logic r, a, d;
        logic [3:0] m, k;
        logic [9:0] e;
        do_reset();
        model_step(1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000);
        k = 4'b0000;
        for (int n = 0; n < 4000; n++) begin
            r = ($urandom_range(0, 599) == 0);
            d = ($urandom_range(0, 69) == 0);
            a = ($urandom_range(0, 7) == 0);
            for (int i = 0; i < 4; i++) m[i] = ($urandom_range(0, 9) < 4);
            if ($urandom_range(0, 49) == 0) k = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            reset = r;
            tick(a, d, m, k);
            model_step(r, a, d, m, k);
            e = exp_outs(m_state, m_latch);
            tests++;
            if (outs !== e) begin
                fails++; $display("FAIL random n=%0d: got %b want %b", n, outs, e);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_arm_exit();
        test_trigger_alarm();
        test_mask_glitch();
        test_disarm_priority();
        test_reset_mid_alarm();
        test_exit_motion();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
